// File: rtl/cisc_isa_pkg.sv
// rtl/cisc_isa_pkg.sv - opcode table, field layout and fetch FSM states shared by fetch unit and engine
// Contents: ISA_ADDR_W / ISA_INST_W defaults, OP_* opcode constants, instruction field
//           bit positions, fetchStateT FSM encoding, is_legal_opcode() lookup.
package cisc_isa_pkg;

    localparam int ISA_ADDR_W = 7;
    localparam int ISA_INST_W = 32;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_ADD       = 8'h01;
    localparam logic [7:0] OP_SUB       = 8'h02;
    localparam logic [7:0] OP_TRANSPOSE = 8'h03;
    localparam logic [7:0] OP_SCALE     = 8'h04;
    localparam logic [7:0] OP_MULT      = 8'h05;
    localparam logic [7:0] OP_HALT      = 8'hFF;

    // Instruction word layout: opcode | dest | src1 | src2
    localparam int FIELD_W    = 8;
    localparam int OPCODE_LSB = 24;
    localparam int DEST_LSB   = 16;
    localparam int SRC1_LSB   = 8;
    localparam int SRC2_LSB   = 0;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StFull,
        StStop,
        StError
    } fetchStateT;

    function automatic logic is_legal_opcode(input logic [7:0] opcode);
        case (opcode)
            OP_NOP, OP_ADD, OP_SUB, OP_TRANSPOSE,
            OP_SCALE, OP_MULT, OP_HALT: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush, count, full and empty
// Ports: clk, rst_n (async active-low), flush (drops all entries), push/pushData,
//        pop, headData (registered head entry), count, full, empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 39
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    output logic [WIDTH-1:0]           headData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Head comes straight from storage registers, so downstream sees no path from pushData.
    assign headData = mem[rdPtr];
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - ROM fetch FSM, prefetch buffer and field decode for the execution engine
// Ports: clk, reset (async active-low); ROM side inst_enable/inst_address/inst_data/inst_did_read;
//        engine side dec_valid/dec_ready and decoded fields dec_opcode/dec_dest/dec_src1/dec_src2/
//        dec_pc/dec_illegal; control redirect/redirect_pc; status halted/fetch_error.
module instruction_fetch_unit
    import cisc_isa_pkg::*;
#(
    parameter int ADDR_W   = ISA_ADDR_W,
    parameter int INST_W   = ISA_INST_W,
    parameter int DEPTH    = 2,
    parameter int START_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              inst_enable,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [INST_W-1:0] inst_data,
    input  logic              inst_did_read,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [7:0]        dec_opcode,
    output logic [7:0]        dec_dest,
    output logic [7:0]        dec_src1,
    output logic [7:0]        dec_src2,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              dec_illegal,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic              fetch_error
);

    localparam int ENTRY_W = ADDR_W + INST_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int TMR_W   = $clog2(TIMEOUT + 1);

    fetchStateT          state;
    logic [ADDR_W-1:0]   pc;
    logic [TMR_W-1:0]    waitCycles;
    logic                instEnableQ;
    logic                haltedQ;
    logic                fetchErrorQ;

    logic [ENTRY_W-1:0]  headEntry;
    logic [INST_W-1:0]   headInst;
    logic [CNT_W-1:0]    fifoCount;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                push;
    logic                pop;
    logic                roomAfterPush;

    // Redirect suppresses both sides so a flush never races with a same-cycle push or pop.
    assign push = (state == StReq) && inst_did_read && !redirect && !fifoFull;
    assign pop  = !fifoEmpty && dec_ready && !redirect;

    // A push this cycle still leaves a slot if an entry leaves at the same time.
    assign roomAfterPush = pop || (fifoCount < CNT_W'(DEPTH - 1));

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .flush    (redirect),
        .push     (push),
        .pushData ({pc, inst_data}),
        .pop      (pop),
        .headData (headEntry),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            pc          <= ADDR_W'(START_PC);
            waitCycles  <= '0;
            instEnableQ <= 1'b0;
            haltedQ     <= 1'b0;
            fetchErrorQ <= 1'b0;
        end else if (redirect) begin
            state       <= StReq;
            pc          <= redirect_pc;
            waitCycles  <= '0;
            instEnableQ <= 1'b1;
            haltedQ     <= 1'b0;
            fetchErrorQ <= 1'b0;
        end else begin
            if (pop && (headInst[OPCODE_LSB +: FIELD_W] == OP_HALT)) begin
                haltedQ <= 1'b1;
            end
            case (state)
                StIdle: begin
                    state       <= StReq;
                    instEnableQ <= 1'b1;
                end
                StReq: begin
                    if (inst_did_read) begin
                        pc         <= pc + 1'b1;
                        waitCycles <= '0;
                        if (inst_data[OPCODE_LSB +: FIELD_W] == OP_HALT) begin
                            state       <= StStop;
                            instEnableQ <= 1'b0;
                        end else if (!roomAfterPush) begin
                            state       <= StFull;
                            instEnableQ <= 1'b0;
                        end
                    end else if (waitCycles == TMR_W'(TIMEOUT - 1)) begin
                        state       <= StError;
                        instEnableQ <= 1'b0;
                        fetchErrorQ <= 1'b1;
                    end else begin
                        waitCycles <= waitCycles + 1'b1;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state       <= StReq;
                        instEnableQ <= 1'b1;
                    end
                end
                default: ;  // StStop and StError wait for reset or redirect
            endcase
        end
    end

    assign headInst     = headEntry[INST_W-1:0];
    assign inst_enable  = instEnableQ;
    assign inst_address = pc;
    assign dec_valid    = !fifoEmpty;
    assign dec_pc       = headEntry[ENTRY_W-1 -: ADDR_W];
    assign dec_opcode   = headInst[OPCODE_LSB +: FIELD_W];
    assign dec_dest     = headInst[DEST_LSB +: FIELD_W];
    assign dec_src1     = headInst[SRC1_LSB +: FIELD_W];
    assign dec_src2     = headInst[SRC2_LSB +: FIELD_W];
    assign dec_illegal  = !fifoEmpty && !is_legal_opcode(dec_opcode);
    assign halted       = haltedQ;
    assign fetch_error  = fetchErrorQ;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_enable;
    logic [6:0]  inst_address;
    logic [31:0] inst_data;
    logic        inst_did_read;
    logic        dec_valid;
    logic        dec_ready;
    logic [7:0]  dec_opcode;
    logic [7:0]  dec_dest;
    logic [7:0]  dec_src1;
    logic [7:0]  dec_src2;
    logic [6:0]  dec_pc;
    logic        dec_illegal;
    logic        redirect;
    logic [6:0]  redirect_pc;
    logic        halted;
    logic        fetch_error;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .inst_enable   (inst_enable),
        .inst_address  (inst_address),
        .inst_data     (inst_data),
        .inst_did_read (inst_did_read),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_opcode    (dec_opcode),
        .dec_dest      (dec_dest),
        .dec_src1      (dec_src1),
        .dec_src2      (dec_src2),
        .dec_pc        (dec_pc),
        .dec_illegal   (dec_illegal),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .fetch_error   (fetch_error)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] rom [128];
    int          romMode  = 0;   // 0 silent, 1 DidRead one cycle after enable, 2 DidRead every cycle
    int          fetchCnt = 0;
    logic [6:0]  popPc[$];
    logic [31:0] popWord[$];
    logic        popIll[$];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkPop(input string tag, input int idx, input logic [6:0] expPc,
                            input logic [31:0] expWord, input logic expIll);
        if (idx < popPc.size()) begin
            checkEq({tag, "_pc"},   32'(popPc[idx]), 32'(expPc));
            checkEq({tag, "_word"}, popWord[idx],    expWord);
            checkEq({tag, "_ill"},  32'(popIll[idx]), 32'(expIll));
        end else begin
            checkEq({tag, "_missing"}, 32'(popPc.size()), 32'(idx + 1));
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clearLog();
        popPc.delete();
        popWord.delete();
        popIll.delete();
        fetchCnt = 0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        cyc(2);
        clearLog();
        reset = 1'b1;
    endtask

    function automatic logic [31:0] defWord(input int i);
        return {8'h01, 8'h80 | 8'(i), 8'hA5, 8'h3C};
    endfunction

    // ROM model drives on the falling edge; the log samples later in the same half-cycle.
    initial begin
        inst_did_read = 1'b0;
        inst_data     = '0;
        forever begin
            @(negedge clk);
            case (romMode)
                1:       inst_did_read = inst_enable && !inst_did_read;
                2:       inst_did_read = inst_enable;
                default: inst_did_read = 1'b0;
            endcase
            inst_data = rom[inst_address];
            #3;
            if (reset && !redirect) begin
                if (dec_valid && dec_ready) begin
                    popPc.push_back(dec_pc);
                    popWord.push_back({dec_opcode, dec_dest, dec_src1, dec_src2});
                    popIll.push_back(dec_illegal);
                end
                if (inst_enable && inst_did_read) fetchCnt++;
            end
        end
    end

    initial begin
        reset = 1'b0;
        dec_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        for (int i = 0; i < 128; i++) rom[i] = defWord(i);
        cyc(2);

        // Reset state
        checkEq("rst_enable",  32'(inst_enable), 0);
        checkEq("rst_address", 32'(inst_address), 0);
        checkEq("rst_valid",   32'(dec_valid), 0);
        checkEq("rst_fields",  {dec_opcode, dec_dest, dec_src1, dec_src2}, 0);
        checkEq("rst_pc",      32'(dec_pc), 0);
        checkEq("rst_status",  32'({halted, fetch_error, dec_illegal}), 0);

        // 1: ADD, SUB, HALT delivered in order, then fetch stops
        rom[0] = 32'h01102030;
        rom[1] = 32'h02112233;
        rom[2] = 32'hFF000000;
        romMode = 1;
        dec_ready = 1'b1;
        doReset();
        cyc(15);
        checkEq("t1_pops", 32'(popPc.size()), 3);
        checkPop("t1_e0", 0, 7'd0, 32'h01102030, 1'b0);
        checkPop("t1_e1", 1, 7'd1, 32'h02112233, 1'b0);
        checkPop("t1_e2", 2, 7'd2, 32'hFF000000, 1'b0);
        checkEq("t1_halted", 32'(halted), 1);
        checkEq("t1_enable", 32'(inst_enable), 0);
        checkEq("t1_fetches", 32'(fetchCnt), 3);
        for (int i = 0; i < 3; i++) rom[i] = defWord(i);

        // 2: backpressure fills exactly DEPTH entries, head held stable
        dec_ready = 1'b0;
        doReset();
        cyc(20);
        checkEq("t2_fetches", 32'(fetchCnt), 2);
        checkEq("t2_enable",  32'(inst_enable), 0);
        checkEq("t2_address", 32'(inst_address), 2);
        checkEq("t2_valid",   32'(dec_valid), 1);
        checkEq("t2_pc",      32'(dec_pc), 0);
        checkEq("t2_fields",  {dec_opcode, dec_dest, dec_src1, dec_src2}, 32'h0180A53C);
        dec_ready = 1'b1;
        cyc(12);
        checkPop("t2_e0", 0, 7'd0, defWord(0), 1'b0);
        checkPop("t2_e1", 1, 7'd1, defWord(1), 1'b0);
        checkPop("t2_e2", 2, 7'd2, defWord(2), 1'b0);

        // 3: redirect coinciding with DidRead drops the word; then PC wrap
        doReset();
        cyc(2);
        for (int k = 0; k < 10 && !inst_did_read; k++) cyc();
        checkEq("t3_sync", 32'(inst_did_read), 1);
        redirect = 1'b1;
        redirect_pc = 7'd100;
        clearLog();
        cyc();
        redirect = 1'b0;
        checkEq("t3_valid",   32'(dec_valid), 0);
        checkEq("t3_address", 32'(inst_address), 100);
        checkEq("t3_enable",  32'(inst_enable), 1);
        cyc(8);
        checkPop("t3_first", 0, 7'd100, defWord(100), 1'b0);
        redirect = 1'b1;
        redirect_pc = 7'd126;
        clearLog();
        cyc();
        redirect = 1'b0;
        cyc(10);
        checkPop("t3_w126", 0, 7'd126, defWord(126), 1'b0);
        checkPop("t3_w127", 1, 7'd127, defWord(127), 1'b0);
        checkPop("t3_w0",   2, 7'd0,   defWord(0),   1'b0);

        // 4: DidRead timeout, cleared by redirect
        romMode = 0;
        doReset();
        cyc(15);
        checkEq("t4_err_early", 32'(fetch_error), 0);
        checkEq("t4_en_early",  32'(inst_enable), 1);
        cyc();
        checkEq("t4_err",    32'(fetch_error), 1);
        checkEq("t4_enable", 32'(inst_enable), 0);
        romMode = 1;
        redirect = 1'b1;
        redirect_pc = 7'd5;
        clearLog();
        cyc();
        redirect = 1'b0;
        checkEq("t4_err_clr", 32'(fetch_error), 0);
        checkEq("t4_restart", 32'(inst_enable), 1);
        cyc(6);
        checkPop("t4_first", 0, 7'd5, defWord(5), 1'b0);

        // 5: illegal opcode flagged on its own entry; one word per cycle
        rom[3] = 32'h7E123456;
        romMode = 2;
        doReset();
        cyc(10);
        checkEq("t5_pops", 32'(popPc.size()), 8);
        checkPop("t5_e2", 2, 7'd2, defWord(2), 1'b0);
        checkPop("t5_e3", 3, 7'd3, 32'h7E123456, 1'b1);
        checkPop("t5_e4", 4, 7'd4, defWord(4), 1'b0);
        checkEq("t5_valid", 32'(dec_valid), 1);
        rom[3] = defWord(3);

        // 6: asynchronous reset mid-handshake
        romMode = 1;
        doReset();
        cyc(2);
        for (int k = 0; k < 10 && !inst_did_read; k++) cyc();
        checkEq("t6_sync", 32'(inst_did_read), 1);
        #1 reset = 1'b0;
        #1;
        checkEq("t6_enable",  32'(inst_enable), 0);
        checkEq("t6_address", 32'(inst_address), 0);
        checkEq("t6_valid",   32'(dec_valid), 0);
        checkEq("t6_fields",  {dec_opcode, dec_dest, dec_src1, dec_src2}, 0);
        checkEq("t6_status",  32'({halted, fetch_error}), 0);
        clearLog();
        cyc();
        reset = 1'b1;
        cyc(8);
        checkPop("t6_first", 0, 7'd0, defWord(0), 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
